// File: rtl/duckhunt_pkg.sv
// Shared state codes and constants for the duck hunt round sequencer.
package duckhunt_pkg;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    WALK      = 4'd1,
    JUMP      = 4'd2,
    FLY       = 4'd3,
    FALL      = 4'd4,
    ESCAPE    = 4'd5,
    SHOW      = 4'd6,
    NEXT      = 4'd7,
    ROUND_END = 4'd8,
    GAME_OVER = 4'd9
  } state_t;

  localparam logic [15:0] BCD_MAX = 16'h9999;
  localparam logic [1:0]  SHOTS   = 2'd3;

endpackage

// File: rtl/bcd_score_add.sv
// Adds 5 to a 4-digit BCD score, clamping at 9999 on overflow.
module bcd_score_add
  import duckhunt_pkg::*;
(
  input  logic [15:0] score,
  output logic [15:0] sum
);

  logic [4:0] t;
  logic [4:0] c;

  always_comb begin
    sum = '0;
    t   = '0;
    c   = 5'd5;
    for (int i = 0; i < 4; i++) begin
      t = {1'b0, score[i*4 +: 4]} + c;
      if (t > 5'd9) begin
        sum[i*4 +: 4] = 4'(t - 5'd10);
        c = 5'd1;
      end else begin
        sum[i*4 +: 4] = t[3:0];
        c = 5'd0;
      end
    end
    if (c != 5'd0) sum = BCD_MAX;
  end

endmodule

// File: rtl/round_sequencer.sv
// Duck hunt round sequencer: dog walk/jump, duck flight, shots,
// hit counting, BCD score and round progression.
module round_sequencer
  import duckhunt_pkg::*;
#(
  parameter int WALK_TICKS      = 30,
  parameter int JUMP_TICKS      = 10,
  parameter int FLY_TICKS       = 50,
  parameter int FALL_TICKS      = 15,
  parameter int SHOW_TICKS      = 20,
  parameter int DUCKS_PER_ROUND = 10,
  parameter int PASS_HITS       = 6
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        ANIM_Clk,
  input  logic        Run,
  input  logic        Trigger,
  input  logic        Hit,
  output logic [3:0]  State,
  output logic        jump2Signal,
  output logic        resetSignal,
  output logic        duck_active,
  output logic [1:0]  shots_left,
  output logic [3:0]  ducks_hit,
  output logic [3:0]  duck_num,
  output logic [3:0]  round_num,
  output logic [15:0] score_bcd
);

  localparam logic [7:0] WALK_L = 8'(WALK_TICKS);
  localparam logic [7:0] JUMP_L = 8'(JUMP_TICKS);
  localparam logic [7:0] FLY_L  = 8'(FLY_TICKS);
  localparam logic [7:0] FALL_L = 8'(FALL_TICKS);
  localparam logic [7:0] SHOW_L = 8'(SHOW_TICKS);
  localparam logic [3:0] LAST_D = 4'(DUCKS_PER_ROUND - 1);
  localparam logic [3:0] PASS_L = 4'(PASS_HITS);

  logic [2:0]  s1, s2, s3, edges;
  logic [1:0]  fill;
  logic        tick, run_p, trig_p;
  state_t      state, state_n;
  logic [7:0]  cnt, cnt_n, lim;
  logic [1:0]  shots, shots_n;
  logic [3:0]  hits, hits_n;
  logic [3:0]  duck, duck_n;
  logic [3:0]  round, round_n;
  logic [15:0] score, score_n, score_inc;
  logic        jump_n, rsig_n;

  bcd_score_add u_add (
    .score (score),
    .sum   (score_inc)
  );

  // Edges are masked until s3 holds a real sample, so a level
  // held through reset never looks like a fresh press.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1   <= '0;
      s2   <= '0;
      s3   <= '0;
      fill <= '0;
    end else begin
      s1 <= {Trigger, Run, ANIM_Clk};
      s2 <= s1;
      s3 <= s2;
      if (fill != 2'd3) fill <= fill + 2'd1;
    end
  end

  assign edges  = (fill == 2'd3) ? (s2 & ~s3) : 3'b000;
  assign tick   = edges[0];
  assign run_p  = edges[1];
  assign trig_p = edges[2];

  always_comb begin
    case (state)
      WALK:         lim = WALK_L;
      JUMP:         lim = JUMP_L;
      FLY:          lim = FLY_L;
      FALL, ESCAPE: lim = FALL_L;
      SHOW:         lim = SHOW_L;
      default:      lim = 8'd0;
    endcase
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    shots_n = shots;
    hits_n  = hits;
    duck_n  = duck;
    round_n = round;
    score_n = score;
    jump_n  = 1'b0;
    rsig_n  = 1'b0;
    if (tick && lim != 8'd0) cnt_n = cnt + 8'd1;
    case (state)
      IDLE: if (run_p) begin
        state_n = WALK;
        rsig_n  = 1'b1;
        score_n = '0;
        hits_n  = '0;
        duck_n  = '0;
        round_n = 4'd1;
      end
      WALK: if (tick && cnt_n == lim) begin
        state_n = JUMP;
        jump_n  = 1'b1;
      end
      JUMP: if (tick && cnt_n == lim) begin
        state_n = FLY;
        shots_n = SHOTS;
      end
      FLY: begin
        // A shot in the same Clk as the timeout tick wins.
        if (trig_p && shots != 2'd0) begin
          cnt_n   = cnt;
          shots_n = shots - 2'd1;
          if (Hit) begin
            state_n = FALL;
            hits_n  = hits + 4'd1;
            score_n = score_inc;
          end else if (shots == 2'd1) begin
            state_n = ESCAPE;
          end
        end else if (tick && cnt_n == lim) begin
          state_n = ESCAPE;
        end
      end
      FALL, ESCAPE: if (tick && cnt_n == lim) state_n = SHOW;
      SHOW: if (tick && cnt_n == lim) state_n = NEXT;
      NEXT: begin
        if (duck == LAST_D) begin
          state_n = ROUND_END;
        end else begin
          state_n = WALK;
          duck_n  = duck + 4'd1;
          rsig_n  = 1'b1;
        end
      end
      ROUND_END: begin
        if (hits >= PASS_L) begin
          state_n = WALK;
          round_n = (round == 4'd15) ? round : round + 4'd1;
          hits_n  = '0;
          duck_n  = '0;
          rsig_n  = 1'b1;
        end else begin
          state_n = GAME_OVER;
        end
      end
      GAME_OVER: if (run_p) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (state_n != state) cnt_n = '0;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= IDLE;
      cnt         <= '0;
      shots       <= '0;
      hits        <= '0;
      duck        <= '0;
      round       <= 4'd1;
      score       <= '0;
      jump2Signal <= 1'b0;
      resetSignal <= 1'b0;
      duck_active <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      shots       <= shots_n;
      hits        <= hits_n;
      duck        <= duck_n;
      round       <= round_n;
      score       <= score_n;
      jump2Signal <= jump_n;
      resetSignal <= rsig_n;
      duck_active <= (state_n == FLY);
    end
  end

  assign State      = state;
  assign shots_left = shots;
  assign ducks_hit  = hits;
  assign duck_num   = duck;
  assign round_num  = round;
  assign score_bcd  = score;

endmodule

// File: tb/tb_round_sequencer.sv
// Bench for round_sequencer: directed game scenarios checked every
// cycle against an integer-score behavioural model.
module tb_round_sequencer;

  localparam int W  = 2;
  localparam int J  = 1;
  localparam int F  = 50;
  localparam int FA = 1;
  localparam int S  = 1;
  localparam int D  = 10;
  localparam int P  = 6;

  logic        Clk = 1'b0;
  logic        Reset, ANIM_Clk, Run, Trigger, Hit;
  logic [3:0]  State;
  logic        jump2Signal, resetSignal, duck_active;
  logic [1:0]  shots_left;
  logic [3:0]  ducks_hit, duck_num, round_num;
  logic [15:0] score_bcd;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  round_sequencer #(
    .WALK_TICKS(W), .JUMP_TICKS(J), .FLY_TICKS(F),
    .FALL_TICKS(FA), .SHOW_TICKS(S),
    .DUCKS_PER_ROUND(D), .PASS_HITS(P)
  ) dut (
    .Clk(Clk), .Reset(Reset), .ANIM_Clk(ANIM_Clk),
    .Run(Run), .Trigger(Trigger), .Hit(Hit),
    .State(State), .jump2Signal(jump2Signal),
    .resetSignal(resetSignal), .duck_active(duck_active),
    .shots_left(shots_left), .ducks_hit(ducks_hit),
    .duck_num(duck_num), .round_num(round_num),
    .score_bcd(score_bcd)
  );

  always #5 Clk = ~Clk;

  // Behavioural model: score is a plain decimal integer.
  int m_state, m_cnt, m_shots, m_hits, m_duck;
  int m_round, m_score, m_jump, m_rsig, m_active, m_fill;
  logic [2:0] ms1, ms2, ms3, me;
  int nst, nj, nr;
  bit adv;

  function automatic int lim_of(input int st);
    case (st)
      1: return W;
      2: return J;
      3: return F;
      4, 5: return FA;
      6: return S;
      default: return 0;
    endcase
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10),
            4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  always @(posedge Clk) begin
    if (Reset) begin
      m_state = 0; m_cnt = 0; m_shots = 0; m_hits = 0;
      m_duck = 0; m_round = 1; m_score = 0;
      m_jump = 0; m_rsig = 0; m_active = 0; m_fill = 0;
      ms1 = 0; ms2 = 0; ms3 = 0;
    end else begin
      me  = (m_fill == 3) ? (ms2 & ~ms3) : 3'b000;
      nst = m_state; nj = 0; nr = 0;
      adv = me[0] && lim_of(m_state) != 0;
      case (m_state)
        0: if (me[1]) begin
          nst = 1; nr = 1; m_score = 0;
          m_hits = 0; m_duck = 0; m_round = 1;
        end
        1: if (adv && m_cnt + 1 == W) begin nst = 2; nj = 1; end
        2: if (adv && m_cnt + 1 == J) begin nst = 3; m_shots = 3; end
        3: begin
          if (me[2] && m_shots > 0) begin
            adv = 0;
            m_shots--;
            if (Hit) begin
              nst = 4; m_hits++;
              m_score = (m_score + 5 > 9999) ? 9999 : m_score + 5;
            end else if (m_shots == 0) nst = 5;
          end else if (adv && m_cnt + 1 == F) nst = 5;
        end
        4, 5: if (adv && m_cnt + 1 == FA) nst = 6;
        6: if (adv && m_cnt + 1 == S) nst = 7;
        7: if (m_duck == D - 1) nst = 8;
           else begin m_duck++; nr = 1; nst = 1; end
        8: if (m_hits >= P) begin
          m_round = (m_round < 15) ? m_round + 1 : 15;
          m_hits = 0; m_duck = 0; nr = 1; nst = 1;
        end else nst = 9;
        9: if (me[1]) nst = 0;
        default: nst = 0;
      endcase
      if (nst != m_state) m_cnt = 0;
      else if (adv) m_cnt++;
      m_state = nst; m_jump = nj; m_rsig = nr;
      m_active = (nst == 3);
      ms3 = ms2; ms2 = ms1;
      ms1 = {Trigger, Run, ANIM_Clk};
      if (m_fill < 3) m_fill++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  always @(negedge Clk) begin
    if (cmp_en) begin
      chk("State", 32'(State), 32'(m_state));
      chk("jump2Signal", 32'(jump2Signal), 32'(m_jump));
      chk("resetSignal", 32'(resetSignal), 32'(m_rsig));
      chk("duck_active", 32'(duck_active), 32'(m_active));
      chk("shots_left", 32'(shots_left), 32'(m_shots));
      chk("ducks_hit", 32'(ducks_hit), 32'(m_hits));
      chk("duck_num", 32'(duck_num), 32'(m_duck));
      chk("round_num", 32'(round_num), 32'(m_round));
      chk("score_bcd", 32'(score_bcd), 32'(to_bcd(m_score)));
    end
  end

  task automatic clk_n(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic do_tick();
    ANIM_Clk = 1'b1; clk_n(1);
    ANIM_Clk = 1'b0; clk_n(1);
  endtask

  task automatic ticks(input int n);
    repeat (n) do_tick();
    clk_n(1);
  endtask

  task automatic press_run();
    Run = 1'b1; clk_n(3);
    Run = 1'b0; clk_n(2);
  endtask

  task automatic shoot(input logic h);
    Hit = h; Trigger = 1'b1; clk_n(3);
    Trigger = 1'b0; Hit = 1'b0; clk_n(2);
  endtask

  task automatic wait_model(input int st);
    int n = 0;
    while (m_state != st && n < 200) begin
      clk_n(1);
      n++;
    end
    if (m_state != st) begin
      checks++;
      errors++;
      $display("FAIL wait_state: model state %0d expected %0d",
               m_state, st);
    end
  endtask

  task automatic to_fly();
    wait_model(1);
    ticks(W + J);
  endtask

  task automatic miss3();
    repeat (3) shoot(1'b0);
  endtask

  task automatic finish_duck();
    ticks(FA + S);
  endtask

  initial begin
    Reset = 1'b1; ANIM_Clk = 1'b0; Run = 1'b0;
    Trigger = 1'b0; Hit = 1'b0;
    clk_n(1);
    cmp_en = 1'b1;
    clk_n(1);
    Reset = 1'b0;
    chk("rst_state", 32'(State), 0);
    chk("rst_round", 32'(round_num), 1);
    chk("rst_score", 32'(score_bcd), 0);
    chk("rst_shots", 32'(shots_left), 0);
    chk("rst_hits", 32'(ducks_hit), 0);
    chk("rst_active", 32'(duck_active), 0);
    clk_n(4);

    press_run();
    chk("run_walk", 32'(State), 1);
    ticks(W);
    chk("walk_jump", 32'(State), 2);
    ticks(J);
    chk("jump_fly", 32'(State), 3);
    chk("fly_shots", 32'(shots_left), 3);
    chk("fly_active", 32'(duck_active), 1);
    shoot(1'b1);
    chk("hit_state", 32'(State), 4);
    chk("hit_score", 32'(score_bcd), 32'h0005);
    chk("hit_shots", 32'(shots_left), 2);
    chk("hit_count", 32'(ducks_hit), 1);
    chk("model_score", 32'(m_score), 5);
    finish_duck();

    to_fly();
    miss3();
    chk("miss_shots", 32'(shots_left), 0);
    chk("miss_escape", 32'(State), 5);
    shoot(1'b1);
    chk("extra_state", 32'(State), 5);
    chk("extra_hits", 32'(ducks_hit), 1);
    chk("extra_score", 32'(score_bcd), 32'h0005);
    finish_duck();

    to_fly();
    ticks(F - 1);
    chk("fly_49", 32'(State), 3);
    ticks(1);
    chk("fly_50", 32'(State), 5);
    finish_duck();

    to_fly();
    ticks(F - 1);
    ANIM_Clk = 1'b1; Trigger = 1'b1; Hit = 1'b1; clk_n(1);
    ANIM_Clk = 1'b0; clk_n(2);
    Trigger = 1'b0; Hit = 1'b0; clk_n(2);
    chk("tie_state", 32'(State), 4);
    chk("tie_hits", 32'(ducks_hit), 2);
    finish_duck();

    for (int i = 4; i < 8; i++) begin
      to_fly(); shoot(1'b1); finish_duck();
    end
    for (int i = 8; i < 10; i++) begin
      to_fly(); miss3(); finish_duck();
    end
    wait_model(1);
    chk("r2_round", 32'(round_num), 2);
    chk("r2_state", 32'(State), 1);
    chk("r2_hits", 32'(ducks_hit), 0);
    chk("r2_score", 32'(score_bcd), 32'h0030);

    for (int i = 0; i < 10; i++) begin
      to_fly();
      if (i < 5) shoot(1'b1);
      else miss3();
      finish_duck();
    end
    wait_model(9);
    chk("go_state", 32'(State), 9);
    chk("go_score", 32'(score_bcd), 32'h0055);
    shoot(1'b1);
    chk("go_hold", 32'(score_bcd), 32'h0055);
    chk("go_hits", 32'(ducks_hit), 5);
    press_run();
    chk("go_idle", 32'(State), 0);

    press_run();
    to_fly(); shoot(1'b1); finish_duck();
    to_fly(); shoot(1'b0);
    chk("pre_rst_shots", 32'(shots_left), 2);
    Run = 1'b1; Reset = 1'b1; clk_n(1);
    Reset = 1'b0;
    chk("mid_rst_state", 32'(State), 0);
    chk("mid_rst_shots", 32'(shots_left), 0);
    chk("mid_rst_hits", 32'(ducks_hit), 0);
    chk("mid_rst_duck", 32'(duck_num), 0);
    chk("mid_rst_score", 32'(score_bcd), 0);
    chk("mid_rst_round", 32'(round_num), 1);
    clk_n(10);
    chk("held_run", 32'(State), 0);
    Run = 1'b0; clk_n(3);
    press_run();
    chk("rerun", 32'(State), 1);

    for (int i = 0; i < 1999; i++) begin
      to_fly(); shoot(1'b1); finish_duck();
    end
    chk("grind_score", 32'(score_bcd), 32'h9995);
    chk("grind_model", 32'(m_score), 9995);
    chk("grind_round", 32'(round_num), 15);
    to_fly(); shoot(1'b1);
    chk("sat_9995", 32'(score_bcd), 32'h9999);
    finish_duck();
    to_fly(); shoot(1'b1);
    chk("sat_9999", 32'(score_bcd), 32'h9999);
    finish_duck();
    clk_n(4);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
